// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake to variable-latency memory, global stall, error flags.
// Optional ack-wait timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic [ADDR_W-1:0] MEM_ALUresult,
    input  logic [DATA_W-1:0] MEM_WriteData,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] MEM_ReadData,
    output logic              MEM_err,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              both_q, both_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              access_s;
    logic              misalign_s;
    logic              stall_s;

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    assign access_s   = MEM_MemRead | MEM_MemWrite;
    assign misalign_s = (MEM_ALUresult[1:0] != 2'b00);
    assign stall_s    = ((state_q == ST_IDLE) & access_s) | (state_q == ST_REQ);

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        both_d  = both_q;
`ifdef MEM_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access_s && misalign_s) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = {DATA_W{1'b0}};
                end else if (access_s) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = MEM_MemWrite;
                    addr_d  = MEM_ALUresult;
                    wdata_d = MEM_WriteData;
                    // Conflicting read+write: the write is performed but flagged.
                    both_d  = MEM_MemRead & MEM_MemWrite;
`ifdef MEM_TIMEOUT_EN
                    wait_d  = {WAIT_W{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = both_q;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = {DATA_W{1'b0}};
                end else begin
                    wait_d  = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
`else
                end else begin
                    state_d = ST_REQ;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and registered-output update; async reset drops any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            err_q   <= 1'b0;
            both_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
`ifdef MEM_TIMEOUT_EN
            wait_q  <= {WAIT_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            both_q  <= both_d;
            cnt_q   <= cnt_d;
`ifdef MEM_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign stall        = stall_s;
    assign MEM_ReadData = rdata_q;
    assign MEM_err      = err_q;
    assign stall_count  = cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; inputs change and outputs are sampled 1ns after each rising edge.
// The timeout scenario runs only when MEM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MEM_MemRead = 1'b0;
    logic        MEM_MemWrite = 1'b0;
    logic [31:0] MEM_ALUresult = 32'd0;
    logic [31:0] MEM_WriteData = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_req, mem_we, stall, MEM_err;
    logic [31:0] mem_addr, mem_wdata, MEM_ReadData;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_ALUresult(MEM_ALUresult), .MEM_WriteData(MEM_WriteData),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall(stall), .MEM_ReadData(MEM_ReadData), .MEM_err(MEM_err), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1: reset state
        repeat (3) step();
        chk("rst_req", mem_req, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst = 1'b1;
        step();
        chk("idle_stall", stall, 32'd0);
        chk("idle_req", mem_req, 32'd0);
        chk("idle_err", MEM_err, 32'd0);
        chk("idle_rdata", MEM_ReadData, 32'd0);
        chk("idle_cnt", stall_count, 32'd0);

        // Test 2: load 0x100, ack in cycle 1
        MEM_MemRead = 1'b1; MEM_ALUresult = 32'h100;
        #1;
        chk("ld_c0_stall", stall, 32'd1);
        chk("ld_c0_req", mem_req, 32'd0);
        step();
        chk("ld_c1_req", mem_req, 32'd1);
        chk("ld_c1_we", mem_we, 32'd0);
        chk("ld_c1_addr", mem_addr, 32'h100);
        chk("ld_c1_stall", stall, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("ld_c2_req", mem_req, 32'd0);
        chk("ld_c2_stall", stall, 32'd0);
        chk("ld_c2_rdata", MEM_ReadData, 32'hDEADBEEF);
        chk("ld_c2_err", MEM_err, 32'd0);
        chk("ld_c2_cnt", stall_count, 32'd2);
        step();
        MEM_MemRead = 1'b0;

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        step();
        mem_ack = 1'b0;
        chk("stray_req", mem_req, 32'd0);
        chk("stray_rdata", MEM_ReadData, 32'hDEADBEEF);
        chk("stray_stall", stall, 32'd0);

        // Test 3: store 0x204, ack on 5th REQ cycle -> 6 stall cycles
        MEM_MemWrite = 1'b1; MEM_ALUresult = 32'h204; MEM_WriteData = 32'h12345678;
        #1;
        chk("st_c0_stall", stall, 32'd1);
        for (int i = 1; i <= 5; i++) begin
            step();
            MEM_WriteData = 32'hFFFF0000;
            MEM_ALUresult = 32'h0;
            chk("st_req", mem_req, 32'd1);
            chk("st_we", mem_we, 32'd1);
            chk("st_addr", mem_addr, 32'h204);
            chk("st_wdata", mem_wdata, 32'h12345678);
            chk("st_stall", stall, 32'd1);
            if (i == 5) mem_ack = 1'b1;
        end
        step();
        mem_ack = 1'b0;
        chk("st_done_stall", stall, 32'd0);
        chk("st_done_req", mem_req, 32'd0);
        chk("st_done_rdata", MEM_ReadData, 32'hDEADBEEF);
        chk("st_done_err", MEM_err, 32'd0);
        chk("st_done_cnt", stall_count, 32'd8);

        // Test 4: back-to-back misaligned load 0x103 right after DONE
        MEM_MemWrite = 1'b0; MEM_MemRead = 1'b1; MEM_ALUresult = 32'h103;
        step();
        chk("mis_c0_stall", stall, 32'd1);
        chk("mis_c0_req", mem_req, 32'd0);
        step();
        chk("mis_c1_req", mem_req, 32'd0);
        chk("mis_c1_stall", stall, 32'd0);
        chk("mis_c1_err", MEM_err, 32'd1);
        chk("mis_c1_rdata", MEM_ReadData, 32'd0);
        chk("mis_c1_cnt", stall_count, 32'd9);
        step();
        MEM_MemRead = 1'b0;

        // Read and write together: write performed, error flagged
        MEM_MemRead = 1'b1; MEM_MemWrite = 1'b1; MEM_ALUresult = 32'h10; MEM_WriteData = 32'hA5A5A5A5;
        step();
        chk("both_we", mem_we, 32'd1);
        chk("both_req", mem_req, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        step();
        mem_ack = 1'b0;
        chk("both_err", MEM_err, 32'd1);
        chk("both_rdata", MEM_ReadData, 32'd0);
        step();
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;

`ifndef MEM_TIMEOUT_EN
        // Long wait: REQ holds indefinitely until ack
        MEM_MemRead = 1'b1; MEM_ALUresult = 32'h40;
        step();
        repeat (20) step();
        chk("long_req", mem_req, 32'd1);
        chk("long_stall", stall, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        mem_ack = 1'b0;
        chk("long_rdata", MEM_ReadData, 32'h0BADF00D);
        chk("long_err", MEM_err, 32'd0);
        step();
        MEM_MemRead = 1'b0;
`else
        // Test 6: timeout after 4 REQ cycles with no ack
        MEM_MemRead = 1'b1; MEM_ALUresult = 32'h400;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("tmo_req", mem_req, 32'd1);
            chk("tmo_stall", stall, 32'd1);
        end
        step();
        chk("tmo_done_req", mem_req, 32'd0);
        chk("tmo_done_stall", stall, 32'd0);
        chk("tmo_done_err", MEM_err, 32'd1);
        chk("tmo_done_rdata", MEM_ReadData, 32'd0);
        step();
        MEM_MemRead = 1'b0;
`endif

        // Test 5: reset mid-REQ, then stray ack
        MEM_MemRead = 1'b1; MEM_ALUresult = 32'h300;
        step();
        chk("r5_req_before", mem_req, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("r5_req_async", mem_req, 32'd0);
        chk("r5_cnt", stall_count, 32'd0);
        MEM_MemRead = 1'b0;
        #1;
        chk("r5_stall", stall, 32'd0);
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEBABE;
        step();
        mem_ack = 1'b0;
        step();
        chk("r5_post_req", mem_req, 32'd0);
        chk("r5_post_stall", stall, 32'd0);
        chk("r5_post_rdata", MEM_ReadData, 32'd0);
        chk("r5_post_err", MEM_err, 32'd0);
        chk("r5_post_cnt", stall_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences the MEM stage's data-memory access over a req/ack handshake to a variable-latency memory. Sits between the EX/MEM pipeline register outputs and the data memory. Asserts a global stall that freezes PC, IF/ID, ID/EX and EX/MEM while an access is outstanding. Delivers read data and error flags to MEM/WB.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
CNT_W, 16, width of stall-cycle counter
TIMEOUT_CYCLES, 255, ack wait limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
MEM_MemRead  in  1  load in MEM stage
MEM_MemWrite  in  1  store in MEM stage
MEM_ALUresult  in  ADDR_W  byte address
MEM_WriteData  in  DATA_W  store data
mem_ack  in  1  memory completion, one-cycle pulse
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, registered
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
stall  out  1  freeze upstream pipeline registers
MEM_ReadData  out  DATA_W  captured load data
MEM_err  out  1  access error flag, valid in DONE
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, MEM_ReadData, MEM_err, stall_count = 0. Reset mid-access drops mem_req immediately. A late mem_ack after reset is ignored.
- access = MEM_MemRead | MEM_MemWrite. Write wins if both are set; MEM_err is set in DONE for that case.
- stall (combinational) = (state==IDLE & access) | (state==REQ).
- In DONE, stall=0, so EX/MEM advances at the end of DONE.
- IDLE, no access: stay.
- IDLE, access, MEM_ALUresult[1:0]!=0 (misaligned): go to DONE. No memory request. MEM_err=1, MEM_ReadData=0.
- IDLE, access, aligned: go to REQ. Register mem_req=1, mem_we=MEM_MemWrite, mem_addr, mem_wdata.
- REQ: mem_req held at 1 with address and data stable until mem_ack.
- REQ, on mem_ack: go to DONE. Drop mem_req. If load, capture mem_rdata into MEM_ReadData. MEM_err=0.
- DONE: one cycle; return to IDLE. MEM_ReadData and MEM_err hold until the next capture.
- Latency: access seen in cycle 0; mem_req high in cycle 1. Ack in cycle 1 gives DONE in cycle 2. Minimum is 2 stall cycles; each extra ack wait adds 1.
- Back-to-back accesses: after DONE, IDLE sees the next access and stalls immediately. There is no gap cycle beyond DONE.
- mem_ack outside REQ: ignored.
- stall_count: increments each cycle stall=1 and saturates at all-ones.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on entry to REQ and increments each cycle in REQ.
  - If it reaches TIMEOUT_CYCLES without mem_ack: drop mem_req, go to DONE, set MEM_err=1, set MEM_ReadData=0.
- MEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely.

Test Plan:
1. Hold rst=0, then release; MemRead=0 and MemWrite=0 -> all outputs 0, state IDLE, stall=0.
2. Load, addr 0x100, ack in cycle 1 with rdata 0xDEADBEEF -> stall high for cycles 0-1; mem_req high in cycle 1 only, mem_we=0; MEM_ReadData=0xDEADBEEF in cycle 2; MEM_err=0; stall_count=2.
3. Store, addr 0x204, data 0x12345678, ack after 5 cycles -> mem_we=1, addr and data stable throughout REQ; stall high for 6 cycles; MEM_ReadData unchanged.
4. Load, addr 0x103 (misaligned) -> no mem_req; one stall cycle; DONE with MEM_err=1 and MEM_ReadData=0.
5. rst pulsed low while in REQ, then stray mem_ack -> mem_req=0 immediately; state IDLE; ack ignored; stall_count=0.
6. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no ack -> mem_req drops after 4 REQ cycles; MEM_err=1; stall releases in DONE.
